// File: rtl/uart_cmd_slave.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_slave
// Description : UART command responder. Receives 11-bit frames (start, 8 data
//               LSB first, even parity, stop) and turns them into register
//               write strobes (2-frame command) or register reads whose byte
//               is returned as one frame on tx (1-frame command).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_slave #(
    parameter int BR           = 434,
    parameter int TIMEOUT_BITS = 32,
    parameter int TURN_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       tx,
    output logic       wr_en,
    output logic [6:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_en,
    output logic [6:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       frame_err,
    output logic       busy
);

    localparam int BW     = (BR > 2) ? $clog2(BR) : 1;
    localparam int TO_CYC = TIMEOUT_BITS * BR;
    localparam int TN_CYC = TURN_BITS * BR;
    localparam int T_MAX  = (TO_CYC > TN_CYC) ? TO_CYC : TN_CYC;
    localparam int TW     = $clog2(T_MAX + 1);

    localparam logic [BW-1:0] C_BAUD_LAST = BW'(BR - 1);
    localparam logic [BW-1:0] C_BAUD_HALF = BW'(BR / 2 - 1);
    localparam logic [TW-1:0] C_TO_LAST   = TW'(TO_CYC - 1);
    localparam logic [TW-1:0] C_TURN_LAST = TW'(TN_CYC - 1);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] R_START  = 4'd1;
    localparam logic [3:0] R_DATA   = 4'd2;
    localparam logic [3:0] R_PARITY = 4'd3;
    localparam logic [3:0] R_STOP   = 4'd4;
    localparam logic [3:0] DECODE   = 4'd5;
    localparam logic [3:0] WAIT_B2  = 4'd6;
    localparam logic [3:0] RD_REQ   = 4'd7;
    localparam logic [3:0] RD_CAP   = 4'd8;
    localparam logic [3:0] TURN     = 4'd9;
    localparam logic [3:0] T_START  = 4'd10;
    localparam logic [3:0] T_DATA   = 4'd11;
    localparam logic [3:0] T_PARITY = 4'd12;
    localparam logic [3:0] T_STOP   = 4'd13;

    logic          rx_meta_q, rx_s_q, rx_prev_q;
    logic [3:0]    state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          par_q, par_d;
    logic          stop_q, stop_d;
    logic          byte2_q, byte2_d;
    logic [6:0]    addr_q, addr_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    txsh_q, txsh_d;
    logic          txpar_q, txpar_d;
    logic          wr_en_q, wr_en_d;
    logic [6:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [6:0]    rd_addr_q, rd_addr_d;
    logic          ferr_d;

    logic rx_fall;
    logic baud_tick;
    logic rx_bad;

    assign rx_fall   = rx_prev_q & ~rx_s_q;
    assign baud_tick = (baud_q == C_BAUD_LAST);
    assign rx_bad    = (par_q != ^sh_q) | ~stop_q;

    // Two-flop synchronizer plus one flop of history for start-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    // Next-state logic for receive, decode, read fetch and response transmit
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        par_d     = par_q;
        stop_d    = stop_q;
        byte2_d   = byte2_q;
        addr_d    = addr_q;
        tmr_d     = tmr_q;
        txsh_d    = txsh_q;
        txpar_d   = txpar_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_addr_d = rd_addr_q;
        ferr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (rx_fall) begin
                    byte2_d = 1'b0;
                    state_d = R_START;
                end
            end
            R_START: begin
                if (baud_q == C_BAUD_HALF) begin
                    baud_d = '0;
                    if (rx_s_q) begin
                        // False start: byte 2 resumes its running timeout
                        state_d = byte2_q ? WAIT_B2 : IDLE;
                    end else begin
                        state_d = R_DATA;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            R_DATA: begin
                if (baud_tick) begin
                    baud_d = '0;
                    sh_d   = {rx_s_q, sh_q[7:1]};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = R_PARITY;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            R_PARITY: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    par_d   = rx_s_q;
                    state_d = R_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            R_STOP: begin
                // Sampled mid-bit; the rest of the stop bit overlaps DECODE
                if (baud_tick) begin
                    baud_d  = '0;
                    stop_d  = rx_s_q;
                    state_d = DECODE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DECODE: begin
                if (rx_bad) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else if (byte2_q) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = sh_q;
                    state_d   = IDLE;
                end else if (sh_q[7]) begin
                    addr_d  = sh_q[6:0];
                    byte2_d = 1'b1;
                    tmr_d   = '0;
                    state_d = WAIT_B2;
                end else begin
                    rd_addr_d = sh_q[6:0];
                    state_d   = RD_REQ;
                end
            end
            WAIT_B2: begin
                baud_d = '0;
                bit_d  = '0;
                if (rx_fall) begin
                    state_d = R_START;
                end else if (tmr_q == C_TO_LAST) begin
                    ferr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            RD_REQ: begin
                state_d = RD_CAP;
            end
            RD_CAP: begin
                txsh_d  = rd_data;
                txpar_d = ^rd_data;
                tmr_d   = '0;
                state_d = TURN;
            end
            TURN: begin
                baud_d = '0;
                bit_d  = '0;
                if (tmr_q == C_TURN_LAST) begin
                    state_d = T_START;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            T_START: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    state_d = T_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            T_DATA: begin
                if (baud_tick) begin
                    baud_d = '0;
                    txsh_d = {1'b0, txsh_q[7:1]};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = T_PARITY;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            T_PARITY: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    state_d = T_STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            T_STOP: begin
                if (baud_tick) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any partial command
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            baud_q    <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            par_q     <= 1'b0;
            stop_q    <= 1'b1;
            byte2_q   <= 1'b0;
            addr_q    <= '0;
            tmr_q     <= '0;
            txsh_q    <= '0;
            txpar_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            byte2_q   <= byte2_d;
            addr_q    <= addr_d;
            tmr_q     <= tmr_d;
            txsh_q    <= txsh_d;
            txpar_q   <= txpar_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    // Serial output decoded from state so reset forces the line high at once
    always_comb begin
        case (state_q)
            T_START:  tx = 1'b0;
            T_DATA:   tx = txsh_q[0];
            T_PARITY: tx = txpar_q;
            default:  tx = 1'b1;
        endcase
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign rd_en     = (state_q == RD_REQ);
    assign rd_addr   = rd_addr_q;
    assign frame_err = ferr_d;
    assign busy      = (state_q != IDLE);

endmodule
`default_nettype wire
